// File: rtl/vmv_col_sequencer.sv
// Column-streaming sequencer for the LANES-wide signed 32-bit vector-multiply datapath.
// Issues one column read per cycle, registers operands for the multiplier, and accumulates products per lane.
module vmv_col_sequencer #(
    parameter int LANES = 5,
    parameter int COLS  = 400,
    parameter int AW    = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [AW-1:0]         cols,
    input  logic                  stall,
    output logic                  rd_en,
    output logic [AW-1:0]         rd_addr,
    input  logic [LANES*32-1:0]   rd_a,
    input  logic [LANES*32-1:0]   rd_b,
    output logic [LANES*32-1:0]   mul_a,
    output logic [LANES*32-1:0]   mul_b,
    input  logic [LANES*32-1:0]   mul_res,
    output logic [LANES*32-1:0]   acc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam int W = LANES * 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [AW-1:0] COLS_MAX = AW'(COLS);
    localparam logic [AW-1:0] ONE_A    = AW'(1);
    localparam logic [AW-1:0] ZERO_A   = AW'(0);

    function automatic logic [31:0] wrap_add(input logic [31:0] x, input logic [31:0] y);
        return x + y;
    endfunction

    logic [1:0]    state_r;
    logic [1:0]    state_s;
    logic [AW-1:0] cnt_r;
    logic [AW-1:0] cnt_s;
    logic [AW-1:0] cols_r;
    logic [AW-1:0] cols_s;
    logic [AW-1:0] cols_clamp_s;
    logic [AW-1:0] issue_addr_s;
    logic          issue_s;
    logic          clear_s;
    logic          out_valid_s;
    logic          rd_valid_r;
    logic          mul_valid_r;
    logic [W-1:0]  acc_s;

    // Oversized job lengths are limited to the matrix width.
    always_comb begin
        if (cols > COLS_MAX) begin
            cols_clamp_s = COLS_MAX;
        end else begin
            cols_clamp_s = cols;
        end
    end

    // Next-state, issue and handshake decisions; every registered output is derived from these.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        cols_s       = cols_r;
        issue_s      = 1'b0;
        issue_addr_s = cnt_r;
        clear_s      = 1'b0;
        out_valid_s  = out_valid;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    clear_s      = 1'b1;
                    cols_s       = cols_clamp_s;
                    issue_addr_s = ZERO_A;
                    if (cols_clamp_s == ZERO_A) begin
                        cnt_s       = ZERO_A;
                        state_s     = ST_DONE;
                        out_valid_s = 1'b1;
                    end else if (stall) begin
                        cnt_s   = ZERO_A;
                        state_s = ST_RUN;
                    end else begin
                        // Column 0 goes out on the acceptance edge so it is visible in cycle 1.
                        issue_s = 1'b1;
                        cnt_s   = ONE_A;
                        if (cols_clamp_s == ONE_A) begin
                            state_s = ST_DRAIN;
                        end else begin
                            state_s = ST_RUN;
                        end
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    issue_s = 1'b1;
                    cnt_s   = cnt_r + ONE_A;
                    if (cnt_r == (cols_r - ONE_A)) begin
                        state_s = ST_DRAIN;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // The last column may still be accumulating on this edge; it lands together with out_valid.
                if (!rd_en && !rd_valid_r) begin
                    state_s     = ST_DONE;
                    out_valid_s = 1'b1;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_s     = ST_IDLE;
                    out_valid_s = 1'b0;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Per-lane wrapping accumulation, cleared when a job is accepted.
    always_comb begin
        acc_s = acc;
        for (int i = 0; i < LANES; i++) begin
            if (clear_s) begin
                acc_s[32*i +: 32] = 32'd0;
            end else if (mul_valid_r) begin
                acc_s[32*i +: 32] = wrap_add(acc[32*i +: 32], mul_res[32*i +: 32]);
            end else begin
                acc_s[32*i +: 32] = acc[32*i +: 32];
            end
        end
    end

    // Control state, issue port and handshake registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= ZERO_A;
            cols_r    <= ZERO_A;
            rd_en     <= 1'b0;
            rd_addr   <= ZERO_A;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            cols_r    <= cols_s;
            rd_en     <= issue_s;
            if (issue_s) begin
                rd_addr <= issue_addr_s;
            end else begin
                rd_addr <= rd_addr;
            end
            out_valid <= out_valid_s;
            busy      <= (state_s != ST_IDLE);
        end
    end

    // Capture and accumulate stages run regardless of stall so in-flight reads always complete.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_r  <= 1'b0;
            mul_valid_r <= 1'b0;
            mul_a       <= {W{1'b0}};
            mul_b       <= {W{1'b0}};
            acc         <= {W{1'b0}};
        end else begin
            rd_valid_r  <= rd_en;
            mul_valid_r <= rd_valid_r;
            if (rd_valid_r) begin
                mul_a <= rd_a;
                mul_b <= rd_b;
            end else begin
                mul_a <= mul_a;
                mul_b <= mul_b;
            end
            acc <= acc_s;
        end
    end

endmodule

// File: tb/tb_vmv_col_sequencer.sv
// Directed bench for vmv_col_sequencer with a synchronous-read memory model, a combinational
// multiplier model and queues of expected read addresses and lane sums.
module tb_vmv_col_sequencer;

    localparam int LANES = 5;
    localparam int COLS  = 400;
    localparam int AW    = 9;
    localparam int W     = LANES * 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] cols;
    logic          stall;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_a = '0;
    logic [W-1:0]  rd_b = '0;
    logic [W-1:0]  mul_a;
    logic [W-1:0]  mul_b;
    logic [W-1:0]  mul_res;
    logic [W-1:0]  acc;
    logic          out_valid;
    logic          out_ready;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int mode   = 0;
    bit stall_en = 1'b0;
    logic [AW-1:0] addr_q[$];
    logic [W-1:0]  acc_q[$];
    logic [W-1:0]  last_exp;

    vmv_col_sequencer #(.LANES(LANES), .COLS(COLS), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .cols(cols), .stall(stall),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_a(rd_a), .rd_b(rd_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_res(mul_res), .acc(acc),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fa(input int m, input int addr, input int lane);
        case (m)
            0:       return 32'(lane + 1);
            1:       return (lane == 0) ? 32'h7FFF_FFFF : 32'd1;
            default: return 32'(addr * 3 - lane * 7 + 1);
        endcase
    endfunction

    function automatic logic [31:0] fb(input int m, input int addr);
        if (m == 2 && (addr % 2) == 1) return 32'h8000_0001;
        else return 32'h7FFF_FFFF;
    endfunction

    function automatic logic [31:0] prod(input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] q;
        logic signed [31:0] p;
        q = $signed(b) / 32'sd2147483647;
        p = $signed(a) * q;
        return p;
    endfunction

    always @(posedge clk) begin
        if (rd_en === 1'b1) begin
            for (int i = 0; i < LANES; i++) begin
                rd_a[32*i +: 32] <= fa(mode, int'(rd_addr), i);
                rd_b[32*i +: 32] <= fb(mode, int'(rd_addr));
            end
        end
    end

    always_comb begin
        mul_res = '0;
        for (int i = 0; i < LANES; i++) begin
            mul_res[32*i +: 32] = prod(mul_a[32*i +: 32], mul_b[32*i +: 32]);
        end
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        stall = stall_en && ((cyc >= 10 && cyc <= 14) || cyc == 200);
        if (rd_en === 1'b1) begin
            if (addr_q.size() == 0) chk("rd_unexpected", W'(rd_en), W'(0));
            else chk("rd_addr", W'(rd_addr), W'(addr_q.pop_front()));
        end
    endtask

    task automatic start_job(input int n, input int m);
        logic [W-1:0] e;
        int nc;
        e  = '0;
        nc = (n > COLS) ? COLS : n;
        for (int c = 0; c < nc; c++) begin
            addr_q.push_back(AW'(c));
            for (int l = 0; l < LANES; l++) begin
                e[32*l +: 32] = e[32*l +: 32] + prod(fa(m, c, l), fb(m, c));
            end
        end
        acc_q.push_back(e);
        mode  = m;
        cols  = AW'(n);
        start = 1'b1;
        stall = 1'b0;
        cyc   = 0;
        tick();
        start = 1'b0;
        chk("busy_c1", W'(busy), W'(1));
        chk("rd_en_c1", W'(rd_en), W'(n != 0));
    endtask

    task automatic wait_ov(input int exp_cyc);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        chk("ov_timeout", W'(out_valid), W'(1));
        chk("ov_cycle", W'(cyc), W'(exp_cyc));
        last_exp = (acc_q.size() != 0) ? acc_q.pop_front() : '0;
        chk("acc", acc, last_exp);
        chk("addr_left", W'(addr_q.size()), W'(0));
    endtask

    task automatic finish_job();
        tick();
        chk("ov_clear", W'(out_valid), W'(0));
        chk("busy_clear", W'(busy), W'(0));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stall = 1'b0; out_ready = 1'b1; cols = '0;
        repeat (3) tick();
        chk("rst_rd_en", W'(rd_en), W'(0));
        chk("rst_rd_addr", W'(rd_addr), W'(0));
        chk("rst_mul_a", mul_a, W'(0));
        chk("rst_mul_b", mul_b, W'(0));
        chk("rst_acc", acc, W'(0));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        rst = 1'b0;
        tick();

        // Full job, then the same job with stalls
        start_job(400, 0); wait_ov(403); finish_job();
        stall_en = 1'b1;
        start_job(400, 0); wait_ov(409); finish_job();
        start_job(20, 2); wait_ov(28); finish_job();
        stall_en = 1'b0;

        // Oversized length clamps to COLS, lane 0 wraps
        start_job(511, 1); wait_ov(403); finish_job();

        // Handshake hold with a start pulse while DONE
        out_ready = 1'b0;
        start_job(3, 2); wait_ov(6);
        for (int k = 0; k < 20; k++) begin
            start = (k == 10);
            tick();
            chk("hold_ov", W'(out_valid), W'(1));
            chk("hold_acc", acc, last_exp);
            chk("hold_busy", W'(busy), W'(1));
        end
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        out_ready = 1'b0;
        start = 1'b0;
        chk("hs_ov", W'(out_valid), W'(0));
        chk("hs_busy", W'(busy), W'(0));
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("idle_busy", W'(busy), W'(0));
            chk("idle_rd_en", W'(rd_en), W'(0));
            chk("idle_acc", acc, last_exp);
        end
        out_ready = 1'b1;

        // Reset in the middle of a long job
        start_job(400, 0);
        while (cyc < 50) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rd_en", W'(rd_en), W'(0));
        chk("mid_rd_addr", W'(rd_addr), W'(0));
        chk("mid_mul_a", mul_a, W'(0));
        chk("mid_mul_b", mul_b, W'(0));
        chk("mid_acc", acc, W'(0));
        chk("mid_out_valid", W'(out_valid), W'(0));
        chk("mid_busy", W'(busy), W'(0));
        addr_q.delete();
        acc_q.delete();
        tick();
        start_job(2, 2); wait_ov(5); finish_job();

        // Zero-length job
        start_job(0, 0); wait_ov(1); finish_job();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
